// File: rtl/neuron_core_wb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_core_wb_slave
//  Description : Wishbone slave front end for the 256-neuron core. Registers
//                in-window requests, issues single-cycle read/write strobes to
//                the core decoder, waits a fixed read latency and returns a
//                registered one-cycle acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_core_wb_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK    = 32'hFFFF_8000,
    parameter int          READ_LATENCY = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic [31:0] core_addr,
    output logic [31:0] core_wdata,
    output logic [3:0]  core_sel,
    output logic        core_we,
    output logic        core_re,
    input  logic [31:0] core_rdata
);

    // Counter preload: WAIT counts down from here to zero, so the capture edge
    // lands READ_LATENCY cycles after the core_re cycle.
    localparam logic [2:0] c_LAT_M1 = 3'(READ_LATENCY - 1);

    // Region codes from core_addr[14:13]; only region 3 is unmapped for reads,
    // and only regions 0/1 (bit 14 clear) accept writes.
    localparam logic [1:0] c_REGION_UNMAPPED = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] r_rd_buf;
    logic [31:0] w_rd_buf_nxt;
    logic        r_ack;
    logic        w_ack_nxt;
    logic [31:0] r_dat;
    logic [31:0] w_dat_nxt;
    logic        r_core_we;
    logic        w_core_we_nxt;
    logic        r_core_re;
    logic        w_core_re_nxt;
    logic        r_we_req;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_sel;

    logic        w_hit;
    logic        w_accept;
    logic [1:0]  w_in_region;
    logic [1:0]  w_lat_region;

    assign w_hit        = ((wb_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    assign w_accept     = (r_state == S_IDLE) & wb_cyc_i & wb_stb_i & w_hit;
    assign w_in_region  = wb_adr_i[14:13];
    assign w_lat_region = r_addr[14:13];

    // State, counter, read buffer and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_rd_buf  <= 32'd0;
            r_ack     <= 1'b0;
            r_dat     <= 32'd0;
            r_core_we <= 1'b0;
            r_core_re <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_buf  <= w_rd_buf_nxt;
            r_ack     <= w_ack_nxt;
            r_dat     <= w_dat_nxt;
            r_core_we <= w_core_we_nxt;
            r_core_re <= w_core_re_nxt;
        end
    end

    // Request latch: captured only on accept, held until the next accept.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_we_req <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_sel    <= 4'h0;
        end else if (w_accept) begin
            r_we_req <= wb_we_i;
            r_addr   <= wb_adr_i;
            r_wdata  <= wb_dat_i;
            r_sel    <= wb_sel_i;
        end
    end

    // Next-state logic. Strobes are decided at accept time so that the
    // registered strobe is high exactly during the CMD cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_buf_nxt  = r_rd_buf;
        w_ack_nxt     = 1'b0;
        w_dat_nxt     = 32'd0;
        w_core_we_nxt = 1'b0;
        w_core_re_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = S_CMD;
                    w_core_we_nxt = wb_we_i & ~w_in_region[1] & (|wb_sel_i);
                    w_core_re_nxt = ~wb_we_i & (w_in_region != c_REGION_UNMAPPED);
                end
            end
            S_CMD: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_we_req) begin
                    w_state_nxt = S_ACK;
                    w_ack_nxt   = 1'b1;
                end else if (w_lat_region == c_REGION_UNMAPPED) begin
                    w_rd_buf_nxt = 32'd0;
                    w_state_nxt  = S_ACK;
                    w_ack_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt   = c_LAT_M1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 3'd0) begin
                    w_rd_buf_nxt = core_rdata;
                    w_dat_nxt    = core_rdata;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign core_addr  = r_addr;
    assign core_wdata = r_wdata;
    assign core_sel   = r_sel;
    assign core_we    = r_core_we;
    assign core_re    = r_core_re;

endmodule
`default_nettype wire

// File: doc/neuron_core_wb_slave.md
# neuron_core_wb_slave

Wishbone slave front end for the 256-neuron core. It registers each bus request that falls in the core's address window and presents a stable address, write data and single-cycle read/write strobes to the core address decoder and storage behind it. It then waits a fixed read latency, captures read data and returns a registered `wb_ack_o`. It sits between the SoC Wishbone interconnect and the core's address decoder.

## Interface
- `BASE_ADDR`, 32'h3000_0000: window base compared against `wb_adr_i`.
- `ADDR_MASK`, 32'hFFFF_8000: bits that must equal `BASE_ADDR` for a hit.
- `READ_LATENCY`, 2: core cycles from `core_re` to valid `core_rdata`; legal range 1..7.
- `wb_clk_i` input 1: single clock, all logic rising-edge.
- `wb_rst_n` input 1: asynchronous, active-low reset.
- `wb_cyc_i` input 1: bus cycle.
- `wb_stb_i` input 1: strobe.
- `wb_we_i` input 1: write enable.
- `wb_sel_i` input 4: byte selects.
- `wb_adr_i` input 32: byte address.
- `wb_dat_i` input 32: write data.
- `wb_ack_o` output 1: registered acknowledge, one-cycle pulse.
- `wb_dat_o` output 32: read data, valid while `wb_ack_o`=1.
- `core_addr` output 32: latched address, drives the decoder.
- `core_wdata` output 32: latched write data.
- `core_sel` output 4: latched byte selects.
- `core_we` output 1: one-cycle write strobe.
- `core_re` output 1: one-cycle read strobe.
- `core_rdata` input 32: read data from the core, valid `READ_LATENCY` cycles after `core_re`.

## Operation
- Hit: `(wb_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)`. Misses are ignored entirely: no strobes, no ack.
- Region: `core_addr[14:13]`, where 00 = synapse, 01 = param, 10 = spike out, 11 = unmapped.
- FSM states and transitions:
  - IDLE: if `wb_cyc_i & wb_stb_i & hit`, latch adr/dat/sel/we and go to CMD.
  - CMD:
    - Write, region 00/01, `sel`≠0: assert `core_we`, go to ACK.
    - Write otherwise (region 10/11 or `sel`=0): no `core_we`, go to ACK.
    - Read, region 11: load `rd_buf`=0, go to ACK.
    - Read otherwise: assert `core_re`, load the 3-bit counter with `READ_LATENCY-1`, go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, capture `core_rdata` into `rd_buf` and go to ACK.
  - ACK: `wb_ack_o`=1, `wb_dat_o`=`rd_buf` for reads (0 for writes), go to IDLE.
- Abort: if `wb_cyc_i`=0 in CMD or WAIT, go to IDLE at the next edge with no ack.
  - A `core_we`/`core_re` issued in CMD is not retracted.
  - `rd_buf` is not updated.
- Latched `core_*` outputs hold until the next accepted request.
- IDLE does not accept during the ACK cycle. The earliest next accept is the cycle after ack.

## Timing
- Reset (asynchronous, `wb_rst_n`=0):
  - State IDLE, counter 0.
  - `wb_ack_o`, `core_we`, `core_re` = 0.
  - `wb_dat_o`, `core_addr`, `core_wdata`, `rd_buf` = 0; `core_sel` = 4'h0.
  - Reset asserted mid-transaction aborts it immediately; no ack after release.
- Request sampled at edge 0; CMD is the cycle after edge 0.
  - Strobes (`core_we`/`core_re`) are high during cycle 1.
  - Write: ack high in cycle 2.
  - Read: `core_rdata` sampled at the end of cycle 1+`READ_LATENCY`; ack in cycle 2+`READ_LATENCY` (cycle 4 for the default).
  - Unmapped read: ack in cycle 2.
- Maximum throughput: one write per 3 cycles; one read per `3+READ_LATENCY` cycles.
- All outputs are registered; no combinational path from `wb_*` inputs to outputs.

## Test plan
- Write 0x1234_5678 to 0x3000_2040, sel=F:
  - Cycle 1: `core_we`=1, `core_addr`=0x3000_2040, `core_wdata`=0x1234_5678.
  - Cycle 2: `wb_ack_o`=1.
- Read 0x3000_0010 with the core returning 0x0000_00A5 two cycles after `core_re`: `core_re` in cycle 1; ack in cycle 4 with `wb_dat_o`=0x0000_00A5.
- Edge-case accesses, each acked in cycle 2 with no core strobe:
  - Read 0x3000_6000 (region 11) → `wb_dat_o`=0.
  - Write 0x3000_4000 (region 10).
  - Write with sel=0.
- Access to 0x3001_0000 (miss) held 10 cycles → no ack, no strobes, `core_addr` unchanged.
- Abort and reset:
  - Read with `wb_cyc_i` dropped in WAIT → no ack; the next read completes normally with fresh data.
  - `wb_rst_n` pulsed low during WAIT → all outputs 0 immediately; no ack after release.
